// File: rtl/conv1d_requant_if.sv
// -----------------------------------------------------------------------------
// conv1d_requant_if
// Purpose : bundles the configuration write port, the accumulator input stream
//           and the packed int8 output stream of conv1d_requant.
// Signals : cfg_we/cfg_addr/cfg_index/cfg_data  - config register writes
//           in_valid/in_ready/in_acc/in_last    - int32 accumulator stream
//           out_valid/out_ready/out_data/out_count - packed int8x4 words
//           busy                                - any data held in the block
// Modports: master drives config + input stream and accepts output words;
//           slave is the conv1d_requant side.
// -----------------------------------------------------------------------------
interface conv1d_requant_if #(
  parameter int INT32_SIZE = 32
);
  logic                  cfg_we;
  logic [2:0]            cfg_addr;
  logic [6:0]            cfg_index;
  logic [INT32_SIZE-1:0] cfg_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [INT32_SIZE-1:0] in_acc;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [INT32_SIZE-1:0] out_data;
  logic [2:0]            out_count;
  logic                  busy;

  modport master (
    output cfg_we, cfg_addr, cfg_index, cfg_data, in_valid, in_acc, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, busy
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_index, cfg_data, in_valid, in_acc, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, busy
  );
endinterface

// File: rtl/conv1d_requant.sv
// -----------------------------------------------------------------------------
// conv1d_requant
// Purpose : output stage after the conv1d accumulator. Adds a per-channel bias,
//           applies fixed-point requantization (Q31 multiplier + shift), adds
//           the output offset, clamps to the activation range and packs int8
//           results little-endian into 32-bit words.
// Ports   : clk  - clock
//           rst  - asynchronous active-high reset
//           bus  - conv1d_requant_if.slave (config, input stream, output stream)
// Pipeline: S1 register (acc + bias read), S2 register (shift/multiply/round),
//           S3 register (rounding right shift), S4 (offset/clamp) writes into
//           the packer. Accept at cycle T -> byte in packer at T+4.
// Option  : define REQUANT_PER_CHANNEL_EN to make MULT and SHIFT per-channel
//           buffers indexed by cfg_index; the channel travels with the data.
// -----------------------------------------------------------------------------
module conv1d_requant #(
  parameter int INT32_SIZE          = 32,
  parameter int BYTE_SIZE           = 8,
  parameter int MAX_OUTPUT_CHANNELS = 128
) (
  input logic             clk,
  input logic             rst,
  conv1d_requant_if.slave bus
);
  localparam int W    = INT32_SIZE;
  localparam int CH_W = $clog2(MAX_OUTPUT_CHANNELS);
  localparam int E_W  = $clog2(W);
  localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] INT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] NUDGE_POS = (2*W)'(1) << (W-2);
  localparam logic signed [2*W-1:0] NUDGE_NEG = (2*W)'(1) - NUDGE_POS;

  localparam logic [2:0] A_BIAS = 3'd0, A_MULT = 3'd1, A_SHIFT = 3'd2, A_OFFSET = 3'd3;
  localparam logic [2:0] A_MIN  = 3'd4, A_MAX  = 3'd5, A_DEPTH = 3'd6, A_CLEAR  = 3'd7;

  // Control
  logic stall, advance, accept, fire, cfg_clear;
  assign stall     = bus.out_valid && !bus.out_ready;
  assign advance   = !stall;
  assign accept    = bus.in_valid && advance;
  assign fire      = bus.out_valid && bus.out_ready;
  assign cfg_clear = bus.cfg_we && (bus.cfg_addr == A_CLEAR);

  // Per-tensor config registers
  logic [W-1:0] offset_q, act_min_q, act_max_q, depth_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset_q  <= '0;
      act_min_q <= -W'(128);
      act_max_q <= W'(127);
      depth_q   <= W'(1);
    end else if (bus.cfg_we) begin
      case (bus.cfg_addr)
        A_OFFSET: offset_q  <= bus.cfg_data;
        A_MIN:    act_min_q <= bus.cfg_data;
        A_MAX:    act_max_q <= bus.cfg_data;
        A_DEPTH:  depth_q   <= bus.cfg_data;
        default:  ;
      endcase
    end
  end

  // Channel counter
  logic [CH_W-1:0] ch_q, ch_d;
  logic            ch_at_end;
  assign ch_at_end = ({{(W-CH_W){1'b0}}, ch_q} == (depth_q - W'(1)));
  always_comb begin
    ch_d = ch_q;
    if (cfg_clear)   ch_d = '0;
    else if (accept) ch_d = (bus.in_last || ch_at_end) ? '0 : ch_q + CH_W'(1);
  end

  // Bias buffer: the read is registered together with the accumulator, so the
  // bias add itself happens at the head of S2.
  logic [W-1:0] bias_mem [MAX_OUTPUT_CHANNELS];
  logic [W-1:0] bias_rd_q;
  always_ff @(posedge clk) begin
    if (bus.cfg_we && bus.cfg_addr == A_BIAS) bias_mem[bus.cfg_index[CH_W-1:0]] <= bus.cfg_data;
    if (accept) bias_rd_q <= bias_mem[ch_q];
  end

  logic [W-1:0] s1_mult, s1_shift;
`ifdef REQUANT_PER_CHANNEL_EN
  // Per-channel multiplier/shift, read alongside the bias for the accepted channel
  logic [W-1:0] mult_mem  [MAX_OUTPUT_CHANNELS];
  logic [W-1:0] shift_mem [MAX_OUTPUT_CHANNELS];
  logic [W-1:0] mult_rd_q, shift_rd_q;
  always_ff @(posedge clk) begin
    if (bus.cfg_we && bus.cfg_addr == A_MULT)  mult_mem[bus.cfg_index[CH_W-1:0]]  <= bus.cfg_data;
    if (bus.cfg_we && bus.cfg_addr == A_SHIFT) shift_mem[bus.cfg_index[CH_W-1:0]] <= bus.cfg_data;
    if (accept) begin
      mult_rd_q  <= mult_mem[ch_q];
      shift_rd_q <= shift_mem[ch_q];
    end
  end
  assign s1_mult  = mult_rd_q;
  assign s1_shift = shift_rd_q;
`else
  logic [W-1:0] mult_q, shift_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_q  <= '0;
      shift_q <= '0;
    end else if (bus.cfg_we) begin
      if (bus.cfg_addr == A_MULT)  mult_q  <= bus.cfg_data;
      if (bus.cfg_addr == A_SHIFT) shift_q <= bus.cfg_data;
    end
  end
  assign s1_mult  = mult_q;
  assign s1_shift = shift_q;
`endif

  // Pipeline registers
  logic         s1_valid_q, s1_last_q, s2_valid_q, s2_last_q, s3_valid_q, s3_last_q;
  logic [W-1:0] s1_acc_q, s2_y_q, s2_shift_q, s3_r_q;

  // S2: bias add, left shift, saturating rounding doubling high multiply
  logic [W-1:0]          x_s2, xs_s2, lsh_s2, y_s2_d;
  logic signed [2*W-1:0] prod_s2, sum_s2, quo_s2;
  always_comb begin
    x_s2    = s1_acc_q + bias_rd_q;
    lsh_s2  = s1_shift[W-1] ? '0 : s1_shift;
    xs_s2   = x_s2 << lsh_s2;
    prod_s2 = $signed({{W{xs_s2[W-1]}}, xs_s2}) * $signed({{W{s1_mult[W-1]}}, s1_mult});
    sum_s2  = prod_s2 + (prod_s2[2*W-1] ? NUDGE_NEG : NUDGE_POS);
    // Arithmetic shift floors; bump negative non-exact results to truncate toward zero
    quo_s2  = sum_s2 >>> (W-1);
    if (sum_s2[2*W-1] && (sum_s2[W-2:0] != '0)) quo_s2 = quo_s2 + (2*W)'(1);
    y_s2_d  = ((xs_s2 == INT_MIN) && (s1_mult == INT_MIN)) ? INT_MAX : quo_s2[W-1:0];
  end

  // S3: rounding right shift, ties away from zero
  logic [W-1:0]   neg_shift_s3, mask_s3, rem_s3, thr_s3, r_s3_d;
  logic [E_W-1:0] e_s3;
  always_comb begin
    neg_shift_s3 = -s2_shift_q;
    if (!s2_shift_q[W-1])                  e_s3 = '0;
    else if (neg_shift_s3 > W'(W-1))       e_s3 = E_W'(W-1);
    else                                   e_s3 = neg_shift_s3[E_W-1:0];
    mask_s3 = (W'(1) << e_s3) - W'(1);
    rem_s3  = s2_y_q & mask_s3;
    thr_s3  = (mask_s3 >> 1) + {{(W-1){1'b0}}, s2_y_q[W-1]};
    r_s3_d  = $unsigned($signed(s2_y_q) >>> e_s3) + ((rem_s3 > thr_s3) ? W'(1) : W'(0));
  end

  // S4: output offset and activation clamp
  logic [W-1:0]         z_s4;
  logic [BYTE_SIZE-1:0] byte_s4;
  always_comb begin
    z_s4 = s3_r_q + offset_q;
    if ($signed(z_s4) < $signed(act_min_q))      byte_s4 = act_min_q[BYTE_SIZE-1:0];
    else if ($signed(z_s4) > $signed(act_max_q)) byte_s4 = act_max_q[BYTE_SIZE-1:0];
    else                                         byte_s4 = z_s4[BYTE_SIZE-1:0];
  end

  // Packer: a handshake empties the word first, so an arriving byte can start
  // the next word in the same cycle.
  logic [W-1:0] pk_data_q, pk_data_d;
  logic [2:0]   pk_count_q, pk_count_d;
  logic         out_valid_q, out_valid_d;
  logic [1:0]   slot;
  always_comb begin
    pk_data_d   = pk_data_q;
    pk_count_d  = pk_count_q;
    out_valid_d = out_valid_q;
    if (fire) begin
      pk_data_d   = '0;
      pk_count_d  = '0;
      out_valid_d = 1'b0;
    end
    slot = pk_count_d[1:0];
    if (cfg_clear) begin
      pk_data_d   = '0;
      pk_count_d  = '0;
      out_valid_d = 1'b0;
    end else if (advance && s3_valid_q) begin
      pk_data_d[int'(slot)*BYTE_SIZE +: BYTE_SIZE] = byte_s4;
      pk_count_d = pk_count_d + 3'd1;
      if (pk_count_d == 3'd4 || s3_last_q) out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;  s1_last_q <= 1'b0;  s1_acc_q   <= '0;
      s2_valid_q  <= 1'b0;  s2_last_q <= 1'b0;  s2_y_q     <= '0;  s2_shift_q <= '0;
      s3_valid_q  <= 1'b0;  s3_last_q <= 1'b0;  s3_r_q     <= '0;
      pk_data_q   <= '0;
      pk_count_q  <= '0;
      out_valid_q <= 1'b0;
      ch_q        <= '0;
    end else begin
      if (advance) begin
        s1_valid_q <= accept;     s1_last_q <= bus.in_last;  s1_acc_q   <= bus.in_acc;
        s2_valid_q <= s1_valid_q; s2_last_q <= s1_last_q;    s2_y_q     <= y_s2_d;
        s2_shift_q <= s1_shift;
        s3_valid_q <= s2_valid_q; s3_last_q <= s2_last_q;    s3_r_q     <= r_s3_d;
      end
      pk_data_q   <= pk_data_d;
      pk_count_q  <= pk_count_d;
      out_valid_q <= out_valid_d;
      ch_q        <= ch_d;
    end
  end

  assign bus.in_ready  = !stall;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = pk_data_q;
  assign bus.out_count = pk_count_q;
  assign bus.busy      = s1_valid_q || s2_valid_q || s3_valid_q || out_valid_q || (pk_count_q != 3'd0);
endmodule

// File: tb/tb_conv1d_requant.sv
module tb_conv1d_requant;
  localparam int NCH     = 128;
  localparam int INT_MIN = int'(32'h8000_0000);
  localparam int INT_MAX = int'(32'h7FFF_FFFF);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv1d_requant_if bus ();
  conv1d_requant dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_mult, m_shift, m_off, m_amin, m_amax, m_depth, m_ch;
  int m_bias [NCH];
  logic [7:0]  m_word [$];
  bit          use_model = 1'b1;
  logic [31:0] exp_data [$];
  int          exp_cnt  [$];
  int          rdy_mode = 1;   // 0 random, 1 always ready, 2 hold off

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail(string name);
    n_checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic model_reset();
    m_mult = 0; m_shift = 0; m_off = 0; m_amin = -128; m_amax = 127; m_depth = 1; m_ch = 0;
    m_word.delete();
  endtask

  // Requantize one accumulator using plain integer arithmetic
  function automatic logic [7:0] ref_byte(int acc, int bias);
    int x, y, r, z, e;
    longint p, nud, a;
    x = acc + bias;
    if (m_shift > 0) x = (m_shift >= 32) ? 0 : (x << m_shift);
    p = longint'(x) * longint'(m_mult);
    if (x == INT_MIN && m_mult == INT_MIN) y = INT_MAX;
    else begin
      nud = (p >= 0) ? (64'sd1 << 30) : (64'sd1 - (64'sd1 << 30));
      y = int'((p + nud) / (64'sd1 << 31));
    end
    e = (m_shift < 0) ? ((m_shift < -31) ? 31 : -m_shift) : 0;
    if (e == 0) r = y;
    else begin
      a = (y < 0) ? -longint'(y) : longint'(y);
      a = (a + (64'sd1 << (e - 1))) / (64'sd1 << e);
      r = (y < 0) ? -int'(a) : int'(a);
    end
    z = r + m_off;
    if (z < m_amin) z = m_amin;
    else if (z > m_amax) z = m_amax;
    return z[7:0];
  endfunction

  task automatic push_exp(logic [31:0] d, int c);
    exp_data.push_back(d);
    exp_cnt.push_back(c);
  endtask

  task automatic accept_model(int acc, bit last);
    logic [7:0]  b;
    logic [31:0] w;
    b = ref_byte(acc, m_bias[m_ch]);
    m_ch = (last || m_ch == m_depth - 1) ? 0 : (m_ch + 1) % NCH;
    if (use_model) begin
      m_word.push_back(b);
      if (m_word.size() == 4 || last) begin
        w = '0;
        foreach (m_word[i]) w[8*i +: 8] = m_word[i];
        push_exp(w, m_word.size());
        m_word.delete();
      end
    end
  endtask

  // All driver tasks start and end at posedge+1
  task automatic cfg_write(int addr, int idx, int data);
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'(addr); bus.cfg_index = 7'(idx); bus.cfg_data = data;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    case (addr)
      0: m_bias[idx] = data;
      1: m_mult  = data;
      2: m_shift = data;
      3: m_off   = data;
      4: m_amin  = data;
      5: m_amax  = data;
      6: m_depth = data;
      default: begin m_ch = 0; m_word.delete(); end
    endcase
  endtask

  task automatic set_ms(int mult, int shift);
`ifdef REQUANT_PER_CHANNEL_EN
    for (int i = 0; i < NCH; i++) begin
      cfg_write(1, i, mult);
      cfg_write(2, i, shift);
    end
`else
    cfg_write(1, 0, mult);
    cfg_write(2, 0, shift);
`endif
  endtask

  task automatic send(int acc, bit last);
    bit ok = 1'b0;
    bus.in_valid = 1'b1; bus.in_acc = acc; bus.in_last = last;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk); ok = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    if (ok) accept_model(acc, last);
    else fail("accept_timeout");
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 3000 && !idle; i++) begin
      @(negedge clk); idle = !bus.busy;
      @(posedge clk); #1;
    end
    if (!idle) fail("drain_timeout");
  endtask

  task automatic cfg_identity(int depth);
    set_ms(INT_MAX, 0);
    cfg_write(3, 0, 0);
    cfg_write(4, 0, -128);
    cfg_write(5, 0, 127);
    cfg_write(6, 0, depth);
    cfg_write(0, 0, 0);
  endtask

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       bus.out_ready = ($urandom_range(0, 3) != 0);
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Scoreboard monitor: every presented word is compared to the queue head
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_data.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_word: got %h count %0d required none", bus.out_data, bus.out_count);
      end else begin
        check("out_data", bus.out_data, exp_data[0]);
        check("out_count", 32'(bus.out_count), 32'(exp_cnt[0]));
        if (bus.out_ready) begin
          $display("word data=%h count=%0d", bus.out_data, bus.out_count);
          void'(exp_data.pop_front());
          void'(exp_cnt.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, n, sh, lo, hi, dep;
    bit seen;
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_index = 0; bus.cfg_data = 0;
    bus.in_valid = 0; bus.in_acc = 0; bus.in_last = 0; bus.out_ready = 1;
    model_reset();
    foreach (m_bias[i]) m_bias[i] = 0;

    // Reset values, during and after reset
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data",  bus.out_data, 0);
    check("rst_out_count", 32'(bus.out_count), 0);
    check("rst_busy",      32'(bus.busy), 0);
    check("rst_in_ready",  32'(bus.in_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_out_valid", 32'(bus.out_valid), 0);
    check("idle_in_ready",  32'(bus.in_ready), 1);
    @(posedge clk); #1;

    // Directed cases with hand-derived expected words
    use_model = 1'b0;
    cfg_identity(1);
    set_ms(32'h4000_0000, 0);
    push_exp(32'h3232_3232, 4);
    repeat (4) send(100, 1'b0);
    wait_idle();

    set_ms(INT_MAX, -1);
    push_exp(32'hFF01_FE02, 4);
    send(3, 0); send(-3, 0); send(1, 0); send(-1, 0);
    wait_idle();

    set_ms(INT_MAX, 0);
    cfg_write(3, 0, -128);
    push_exp(32'h0000_807F, 2);
    send(1000, 0); send(-1000, 1);
    wait_idle();

    cfg_write(3, 0, 0);
    cfg_write(6, 0, 2);
    cfg_write(0, 0, 10);
    cfg_write(0, 1, -10);
    push_exp(32'hF60A_F60A, 4);
    repeat (4) send(0, 1'b0);
    wait_idle();

    cfg_write(6, 0, 3);
    cfg_write(0, 0, 0);
    cfg_write(0, 1, 0);
    cfg_write(0, 2, 50);
    push_exp(32'h0000_0201, 2);
    push_exp(32'h0035_0201, 3);
    send(1, 0); send(2, 1);
    send(1, 0); send(2, 0); send(3, 1);
    wait_idle();

    // CLEAR drops a partial word and rewinds the channel counter
    cfg_write(0, 1, 100);
    send(1, 0);
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    check("partial_busy", 32'(bus.busy), 1);
    @(posedge clk); #1;
    cfg_write(7, 0, 0);
    @(negedge clk);
    check("clear_busy", 32'(bus.busy), 0);
    @(posedge clk); #1;
    push_exp(32'h0000_0005, 1);
    send(5, 1);
    wait_idle();

    // Saturating multiply corner
    use_model = 1'b1;
    cfg_identity(1);
    set_ms(INT_MIN, 0);
    send(INT_MIN, 1);
    wait_idle();

    // Backpressure then asynchronous reset mid-stream
    set_ms(INT_MAX, 0);
    rdy_mode = 2;
    @(posedge clk); #1;
    send(4, 0); send(5, 0); send(6, 0); send(7, 0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk); seen = bus.out_valid;
    end
    if (!seen) fail("stall_word_timeout");
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_acc = 99;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", 32'(bus.in_ready), 0);
    end
    #1 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 0);
    check("arst_busy",      32'(bus.busy), 0);
    check("arst_in_ready",  32'(bus.in_ready), 1);
    check("arst_out_data",  bus.out_data, 0);
    bus.in_valid = 1'b0;
    exp_data.delete();
    exp_cnt.delete();
    model_reset();
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Randomized tensors against the reference model
    for (int t = 0; t < 14; t++) begin
      wait_idle();
      rdy_mode = int'($urandom_range(0, 1));
      sh  = int'($urandom_range(0, 14)) - 10;
      set_ms(int'($urandom()), sh);
      cfg_write(3, 0, int'($urandom_range(0, 255)) - 128);
      lo = int'($urandom_range(0, 128)) - 128;
      hi = int'($urandom_range(0, 127));
      cfg_write(4, 0, lo);
      cfg_write(5, 0, hi);
      dep = int'($urandom_range(1, 5));
      cfg_write(6, 0, dep);
      for (int c = 0; c < dep; c++) cfg_write(0, c, int'($urandom_range(0, 4000)) - 2000);
      n = int'($urandom_range(1, 10));
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        acc = ($urandom_range(0, 3) == 0) ? int'($urandom()) : int'($urandom_range(0, 20000)) - 10000;
        send(acc, k == n - 1);
      end
    end
    rdy_mode = 1;
    wait_idle();
    check("scoreboard_empty", 32'(exp_data.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
